// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch stage and the
// data stage of the pipeline. It latches the winning request, runs a fixed
// MEM_LAT-cycle access, returns read data with a one-cycle valid pulse and
// stalls each requester until its access is acknowledged.
// Optional feature: define ARB_RR_EN for round-robin arbitration; without it
// the data stage always wins over fetch.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned AW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_stall,
  output logic          if_valid,
  output logic [31:0]   if_data,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_wdata,
  output logic          mem_stall,
  output logic          mem_valid,
  output logic [31:0]   mem_rdata,
  output logic          m_en,
  output logic          m_wr,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 32;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t           state;
  state_t           state_next;
  owner_t           owner;
  owner_t           last;
  logic [CNT_W-1:0] cnt;
  logic             flushed;

  logic data_req;
  logic any_req;
  logic grant_data;
  logic start;
  logic capture;
  logic finish;
  logic done_if;
  logic done_data;

  // A data request is a read or a write; both together count as a write.
  assign data_req = mem_rd | mem_wr;
  assign any_req  = if_req | data_req;

  // Arbitration between fetch and data when both ask in the same IDLE cycle.
`ifdef ARB_RR_EN
  assign grant_data = data_req & (~if_req | (last == OWN_IF));
`else
  logic unused_last;
  assign grant_data  = data_req;
  assign unused_last = (last == OWN_DATA);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          start      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the winning command and pace the access with the latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en    <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      owner   <= OWN_IF;
      cnt     <= '0;
    end else begin
      m_en <= start;
      if (start) begin
        owner   <= grant_data ? OWN_DATA : OWN_IF;
        m_addr  <= grant_data ? mem_addr : if_addr;
        m_wr    <= grant_data & mem_wr;
        m_wdata <= grant_data ? mem_wdata : DW'(0);
        cnt     <= CNT_INIT;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Capture read data into the owner's result register on the last BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_data   <= '0;
      mem_rdata <= '0;
    end else if (capture) begin
      if (owner == OWN_IF) begin
        if_data <= m_rdata;
      end else if (!m_wr) begin
        mem_rdata <= m_rdata;
      end
    end
  end

  // Track flushes of an in-flight fetch; cleared when returning to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flushed <= 1'b0;
    end else if (state == DONE) begin
      flushed <= 1'b0;
    end else if ((state == BUSY) && (owner == OWN_IF) && flush) begin
      flushed <= 1'b1;
    end
  end

  // Remember who was served last, for round-robin fairness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= OWN_DATA;
    end else if (finish) begin
      last <= owner;
    end
  end

  // Completion pulses and stalls are decoded from the registered state so a
  // flush arriving in the DONE cycle can still suppress the fetch pulse.
  assign done_if   = (state == DONE) && (owner == OWN_IF);
  assign done_data = (state == DONE) && (owner == OWN_DATA);
  assign if_valid  = done_if & ~flushed & ~flush;
  assign mem_valid = done_data;
  assign if_stall  = if_req & ~done_if;
  assign mem_stall = data_req & ~done_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for arbitration, flush, reset and MEM_LAT=1.
module tb_mem_arbiter;

  localparam int unsigned AW  = 16;
  localparam int unsigned LAT = 4;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   m_rdata;

  logic          if_stall, if_valid, mem_stall, mem_valid, m_en, m_wr;
  logic [31:0]   if_data, mem_rdata, m_wdata;
  logic [AW-1:0] m_addr;

  logic          l1_if_stall, l1_if_valid, l1_mem_stall, l1_mem_valid, l1_m_en, l1_m_wr;
  logic [31:0]   l1_if_data, l1_mem_rdata, l1_m_wdata;
  logic [AW-1:0] l1_m_addr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_valid(if_valid), .if_data(if_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  mem_arbiter #(.MEM_LAT(1), .AW(AW)) dut_lat1 (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_stall(l1_if_stall),
    .if_valid(l1_if_valid), .if_data(l1_if_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(l1_mem_stall), .mem_valid(l1_mem_valid), .mem_rdata(l1_mem_rdata),
    .m_en(l1_m_en), .m_wr(l1_m_wr), .m_addr(l1_m_addr), .m_wdata(l1_m_wdata),
    .m_rdata(m_rdata)
  );

  typedef struct {
    logic        is_data;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 1'b0; if_req = 1'b0; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_wdata = '0; m_rdata = '0;
  endtask

  // Owner of the k-th back-to-back grant in the contention sequence (1 = data).
  function automatic bit slot_is_data(input int k);
    if (RR) return (k % 2) == 1;
    return k == 0;
  endfunction

  initial begin
    vec_t v;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0200, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h0100, 32'h12345678, 32'h55555555, 32'hCAFEF00D};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 32'h0,        32'h00000001, 32'h00000001};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0000, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'hABCD, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hFFFFFFFF};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 16'h1234, 32'h0,        32'h13572468, 32'h13572468};

    // Reset state
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst m_en", m_en, 0);
    chk("rst m_wr", m_wr, 0);
    chk("rst m_addr", m_addr, 0);
    chk("rst m_wdata", m_wdata, 0);
    chk("rst if_valid", if_valid, 0);
    chk("rst if_data", if_data, 0);
    chk("rst mem_valid", mem_valid, 0);
    chk("rst mem_rdata", mem_rdata, 0);
    chk("rst if_stall idle", if_stall, 0);
    chk("rst mem_stall idle", mem_stall, 0);
    next_cycle();
    if_req = 1'b1; mem_wr = 1'b1;
    @(negedge clk);
    chk("rst if_stall req", if_stall, 1);
    chk("rst mem_stall req", mem_stall, 1);
    chk("rst m_en req", m_en, 0);
    next_cycle();
    clear_inputs();
    rst = 1'b0;

    // Single transactions from the table
    for (int n = 0; n < NV; n++) begin
      v = vecs[n];
      for (int c = 0; c <= int'(LAT) + 2; c++) begin
        if (c <= int'(LAT) + 1) begin
          if_req = ~v.is_data; mem_rd = v.is_data & v.rd; mem_wr = v.is_data & v.wr;
        end else begin
          if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        end
        if_addr   = v.is_data ? 16'h7777 : v.addr;
        mem_addr  = v.is_data ? v.addr : 16'h6666;
        mem_wdata = v.wdata;
        m_rdata   = (c == int'(LAT)) ? v.rdata : (32'hBAD0_0000 | 32'(c));
        @(negedge clk);
        chk($sformatf("tbl%0d c%0d m_en", n, c), m_en, 32'(c == 1));
        chk($sformatf("tbl%0d c%0d own_valid", n, c), v.is_data ? mem_valid : if_valid,
            32'(c == int'(LAT) + 1));
        chk($sformatf("tbl%0d c%0d other_valid", n, c), v.is_data ? if_valid : mem_valid, 0);
        chk($sformatf("tbl%0d c%0d own_stall", n, c), v.is_data ? mem_stall : if_stall,
            32'(c <= int'(LAT)));
        if (c >= 1 && c <= int'(LAT)) begin
          chk($sformatf("tbl%0d c%0d m_addr", n, c), 32'(m_addr), 32'(v.addr));
          chk($sformatf("tbl%0d c%0d m_wr", n, c), m_wr, 32'(v.is_data & v.wr));
          if (v.is_data && v.wr) chk($sformatf("tbl%0d c%0d m_wdata", n, c), m_wdata, v.wdata);
        end
        if (c == int'(LAT) + 1)
          chk($sformatf("tbl%0d data", n), v.is_data ? mem_rdata : if_data, v.exp_data);
        next_cycle();
      end
    end

    // Contention: both stages requesting from reset
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bit vslot, eslot, vdata, edata;
      if_req = 1'b1; if_addr = 16'h00A0;
      mem_rd = RR ? 1'b1 : (c <= 5); mem_addr = 16'h00B0;
      m_rdata = 32'h1000_0000 + 32'(c);
      vslot = (c >= 5) && ((c - 5) % 6 == 0);
      vdata = slot_is_data((c - 5) / 6);
      eslot = (c >= 1) && ((c - 1) % 6 == 0);
      edata = slot_is_data((c - 1) / 6);
      @(negedge clk);
      chk($sformatf("arb c%0d if_valid", c), if_valid, 32'(vslot && !vdata));
      chk($sformatf("arb c%0d mem_valid", c), mem_valid, 32'(vslot && vdata));
      chk($sformatf("arb c%0d if_stall", c), if_stall, 32'(!(vslot && !vdata)));
      chk($sformatf("arb c%0d mem_stall", c), mem_stall, 32'(mem_rd && !(vslot && vdata)));
      chk($sformatf("arb c%0d m_en", c), m_en, 32'(eslot));
      if (eslot) chk($sformatf("arb c%0d m_addr", c), 32'(m_addr), edata ? 32'h00B0 : 32'h00A0);
      if (vslot) chk($sformatf("arb c%0d data", c), vdata ? mem_rdata : if_data,
                     32'h1000_0000 + 32'(c - 1));
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    // Flush of an in-flight fetch, then a fresh fetch
    for (int c = 0; c < 12; c++) begin
      if_req  = 1'b1;
      if_addr = (c <= 5) ? 16'h0040 : 16'h0044;
      flush   = (c == 2);
      m_rdata = 32'h2000_0000 + 32'(c);
      @(negedge clk);
      chk($sformatf("flush c%0d if_valid", c), if_valid, 32'(c == 11));
      chk($sformatf("flush c%0d if_stall", c), if_stall, 32'(!(c == 5 || c == 11)));
      chk($sformatf("flush c%0d m_en", c), m_en, 32'(c == 1 || c == 7));
      chk($sformatf("flush c%0d mem_valid", c), mem_valid, 0);
      if (c == 7) chk("flush m_addr", 32'(m_addr), 32'h0044);
      if (c == 11) chk("flush if_data", if_data, 32'h2000_000A);
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    // Reset in the middle of a data read, then a fresh read
    for (int c = 0; c < 11; c++) begin
      mem_rd   = 1'b1;
      mem_addr = 16'h0300;
      m_rdata  = 32'h3000_0000 + 32'(c);
      rst      = (c == 3 || c == 4);
      @(negedge clk);
      chk($sformatf("rstmid c%0d mem_valid", c), mem_valid, 32'(c == 10));
      chk($sformatf("rstmid c%0d m_en", c), m_en, 32'(c == 1 || c == 6));
      if (c == 2) chk("rstmid m_addr before", 32'(m_addr), 32'h0300);
      if (c == 3) begin
        chk("rstmid m_addr", 32'(m_addr), 0);
        chk("rstmid m_wr", m_wr, 0);
        chk("rstmid m_wdata", m_wdata, 0);
        chk("rstmid if_data", if_data, 0);
        chk("rstmid mem_rdata", mem_rdata, 0);
        chk("rstmid if_valid", if_valid, 0);
        chk("rstmid mem_stall", mem_stall, 1);
      end
      if (c == 10) chk("rstmid mem_rdata", mem_rdata, 32'h3000_0009);
      next_cycle();
    end
    clear_inputs();

    // MEM_LAT=1 instance: enable and capture in one BUSY cycle
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if_req  = (c <= 2);
      if_addr = 16'h0055;
      m_rdata = 32'h4000_0000 + 32'(c);
      @(negedge clk);
      chk($sformatf("lat1 c%0d m_en", c), l1_m_en, 32'(c == 1));
      chk($sformatf("lat1 c%0d if_valid", c), l1_if_valid, 32'(c == 2));
      chk($sformatf("lat1 c%0d if_stall", c), l1_if_stall, 32'(c <= 1));
      if (c == 1) chk("lat1 m_addr", 32'(l1_m_addr), 32'h0055);
      if (c == 2) chk("lat1 if_data", l1_if_data, 32'h4000_0001);
      next_cycle();
    end
    clear_inputs();
    next_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Multi-cycle arbiter and sequencer that shares one unified single-port memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage pipeline. It latches the winning request, drives the memory for a fixed `MEM_LAT`-cycle access, returns read data with a one-cycle valid pulse, and generates per-requester stall signals that freeze the pipeline while an access is pending. Fetch transactions can be cancelled by the pipeline flush.

## Interface
- `MEM_LAT`, 4: memory access latency in cycles, legal range 1..15.
- `AW`, 16: word-address width.

- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: cancels delivery of an in-flight fetch access.
- `if_req` in 1: fetch read request; held stable while `if_stall`=1.
- `if_addr` in AW: fetch word address.
- `if_stall` out 1: fetch request pending, not yet acknowledged.
- `if_valid` out 1: one-cycle fetch completion pulse.
- `if_data` out 32: fetched instruction word.
- `mem_rd` / `mem_wr` in 1: data read / write request; held stable while `mem_stall`=1.
- `mem_addr` in AW, `mem_wdata` in 32: data address and write data.
- `mem_stall` out 1: data request pending, not yet acknowledged.
- `mem_valid` out 1: one-cycle data completion pulse (reads and writes).
- `mem_rdata` out 32: data read result.
- `m_en` out 1, `m_wr` out 1, `m_addr` out AW, `m_wdata` out 32: memory command.
- `m_rdata` in 32: memory read data.

## Operation
- States: IDLE, BUSY, DONE. Registers: `owner` (IF/DATA), `last` (IF/DATA), `cnt` (4 bits), `flushed`.
- IDLE: if any request, pick winner, latch addr/wr/wdata into `m_addr`/`m_wr`/`m_wdata`, `cnt`<=MEM_LAT-1, set `owner`, go BUSY. No request: stay.
- Data request = `mem_rd | mem_wr`; both high is a write.
- BUSY: `m_en`=1 only in the first BUSY cycle; `m_addr`/`m_wr`/`m_wdata` held for all of BUSY. When `cnt`==0: capture `m_rdata` (reads only) into `if_data` or `mem_rdata` per `owner`, go DONE; else `cnt` decrements.
- DONE: pulse `if_valid` (owner IF and `flushed`=0) or `mem_valid` (owner DATA); set `last`<=`owner`; always go to IDLE.
- Writes: `mem_rdata` unchanged.
- `if_stall` = `if_req` & ~(DONE & owner IF); `mem_stall` = data request & ~(DONE & owner DATA). Combinational.
- Flush: `flush`=1 in any BUSY or DONE cycle with owner IF sets `flushed` (and suppresses `if_valid` that same cycle); memory access still completes; `flushed` clears on entering IDLE. Flush does not affect data transactions.

## Timing
- Reset values: state IDLE, `last`=DATA, `cnt`=0, `flushed`=0; `m_en`, `m_wr`, `m_addr`, `m_wdata`, `if_valid`, `if_data`, `mem_valid`, `mem_rdata` all 0. Stalls follow their formulas (equal the request while IDLE).
- Request seen in IDLE at cycle 0: `m_en` at cycle 1, `m_rdata` sampled at cycle MEM_LAT, valid pulse at cycle MEM_LAT+1, stall low in that cycle.
- Throughput: one access per MEM_LAT+2 cycles; IDLE always separates transactions.
- MEM_LAT=1: single BUSY cycle, `m_en` and capture in the same cycle.
- Reset mid-transaction: immediate return to reset values; the memory access is abandoned, nothing is delivered.

## Configuration
- `ARB_RR_EN` defined: round-robin. On simultaneous requests in IDLE, the requester not equal to `last` wins; the first tie after reset goes to IF.
- Not defined: fixed priority, data always beats fetch; `last` is still maintained but unused.

## Test plan
- MEM_LAT=4, `if_req` with `if_addr`=0x0010, `m_rdata`=0xDEADBEEF at cycle 4 -> `m_en` only at cycle 1 with `m_addr`=0x0010, `if_valid` and `if_data`=0xDEADBEEF at cycle 5, `if_stall` high cycles 0-4.
- Without macro, `if_req` and `mem_rd` both at cycle 0 -> `mem_valid` at cycle 5, `if_valid` at cycle 11, `if_stall` high cycles 0-10.
- With `ARB_RR_EN`, both requesting continuously from reset -> grants IF, DATA, IF, DATA; valids at cycles 5, 11, 17, 23.
- `mem_wr` with `mem_addr`=0x0100 and `mem_wdata`=0x12345678 -> `m_en`=`m_wr`=1 at cycle 1 with `m_wdata`=0x12345678; `mem_valid` at cycle 5; `mem_rdata` unchanged.
- Fetch in flight, `flush` pulsed at cycle 2 -> no `if_valid` at cycle 5; IDLE at cycle 6; a new `if_req` at cycle 6 delivers at cycle 11.
- `rst` asserted at cycle 3 during a data read -> all outputs 0 immediately, no `mem_valid`; after release, a fresh read completes in MEM_LAT+1 cycles.
